// File: rtl/uart_cmd_decoder.sv
// Byte-stream command decoder behind the UART receiver: builds AA/BB/CC/DD frames and issues micro-ops.
// Optional inter-byte timeout is built only when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_decoder #(
  parameter int          ADDR_W      = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              par_err,
  input  logic              stp_err,
  input  logic              dn_busy,
  output logic              rf_wr_en,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [7:0]        rf_wr_data,
  output logic              alu_en,
  output logic [3:0]        alu_fun,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              idle
);

  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN, ISSUE} state_t;
  typedef enum logic [1:0] {K_WR, K_RD, K_CC, K_DD} kind_t;

  state_t              state_reg, state_next;
  kind_t               kind_reg, kind_next;
  logic [1:0]          uop_reg, uop_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [7:0]          data_reg, data_next;
  logic [7:0]          a_reg, a_next;
  logic [7:0]          b_reg, b_next;
  logic [3:0]          fun_reg, fun_next;

  logic                wr_en_next, rd_en_next, alu_en_next, err_next;
  logic [ADDR_W-1:0]   rf_addr_next;
  logic [7:0]          rf_wr_data_next;
  logic [3:0]          alu_fun_next;
  logic [1:0]          code_next;

  logic                line_err, pulse_high, timeout;
  logic [1:0]          last_uop;

  assign line_err   = rx_valid & (par_err | stp_err);
  assign pulse_high = rf_wr_en | rf_rd_en | alu_en;
  assign last_uop   = (kind_reg == K_CC) ? 2'd2 : 2'd0;

`ifdef UART_CMD_TIMEOUT_EN
  logic [15:0] cnt_reg;
  logic        in_operand;

  assign in_operand = (state_reg != IDLE) && (state_reg != ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt_reg <= '0;
    else if (rx_valid || !in_operand) cnt_reg <= '0;
    else if (cnt_reg != 16'hFFFF)    cnt_reg <= cnt_reg + 16'd1;
  end

  // A byte arriving in the expiry cycle takes precedence over the timeout.
  assign timeout = in_operand && !rx_valid && (cnt_reg >= TIMEOUT_CYC - 16'd1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    kind_next       = kind_reg;
    uop_next        = uop_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    a_next          = a_reg;
    b_next          = b_reg;
    fun_next        = fun_reg;
    wr_en_next      = 1'b0;
    rd_en_next      = 1'b0;
    alu_en_next     = 1'b0;
    rf_addr_next    = rf_addr;
    rf_wr_data_next = rf_wr_data;
    alu_fun_next    = alu_fun;
    err_next        = 1'b0;
    code_next       = 2'd0;

    case (state_reg)
      IDLE: begin
        uop_next = 2'd0;
        if (line_err) begin
          err_next  = 1'b1;
          code_next = 2'd2;
        end else if (rx_valid) begin
          case (rx_data)
            8'hAA:   begin kind_next = K_WR; state_next = WR_ADDR; end
            8'hBB:   begin kind_next = K_RD; state_next = RD_ADDR; end
            8'hCC:   begin kind_next = K_CC; state_next = OP_A;    end
            8'hDD:   begin kind_next = K_DD; state_next = FUN;     end
            default: begin err_next = 1'b1;  code_next = 2'd1;     end
          endcase
        end
      end

      ISSUE: begin
        if (rx_valid) begin
          err_next  = 1'b1;
          code_next = 2'd0;
        end
        // Leave one cycle after the last issue edge so idle follows the final pulse.
        if (uop_reg > last_uop) begin
          state_next = IDLE;
        end else if (!dn_busy && !pulse_high) begin
          uop_next = uop_reg + 2'd1;
          case (kind_reg)
            K_WR: begin
              wr_en_next      = 1'b1;
              rf_addr_next    = addr_reg;
              rf_wr_data_next = data_reg;
            end
            K_RD: begin
              rd_en_next   = 1'b1;
              rf_addr_next = addr_reg;
            end
            K_CC: begin
              if (uop_reg == 2'd0) begin
                wr_en_next      = 1'b1;
                rf_addr_next    = '0;
                rf_wr_data_next = a_reg;
              end else if (uop_reg == 2'd1) begin
                wr_en_next      = 1'b1;
                rf_addr_next    = ADDR_W'(1);
                rf_wr_data_next = b_reg;
              end else begin
                alu_en_next  = 1'b1;
                alu_fun_next = fun_reg;
              end
            end
            K_DD: begin
              alu_en_next  = 1'b1;
              alu_fun_next = fun_reg;
            end
          endcase
        end
      end

      default: begin
        if (line_err) begin
          err_next   = 1'b1;
          code_next  = 2'd2;
          state_next = IDLE;
        end else if (rx_valid) begin
          case (state_reg)
            WR_ADDR: begin addr_next = rx_data[ADDR_W-1:0]; state_next = WR_DATA; end
            WR_DATA: begin data_next = rx_data;             state_next = ISSUE;   end
            RD_ADDR: begin addr_next = rx_data[ADDR_W-1:0]; state_next = ISSUE;   end
            OP_A:    begin a_next    = rx_data;             state_next = OP_B;    end
            OP_B:    begin b_next    = rx_data;             state_next = FUN;     end
            default: begin fun_next  = rx_data[3:0];        state_next = ISSUE;   end
          endcase
        end else if (timeout) begin
          err_next   = 1'b1;
          code_next  = 2'd3;
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      kind_reg   <= K_WR;
      uop_reg    <= '0;
      addr_reg   <= '0;
      data_reg   <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      fun_reg    <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      alu_en     <= 1'b0;
      rf_addr    <= '0;
      rf_wr_data <= '0;
      alu_fun    <= '0;
      frame_err  <= 1'b0;
      err_code   <= '0;
      idle       <= 1'b1;
    end else begin
      state_reg  <= state_next;
      kind_reg   <= kind_next;
      uop_reg    <= uop_next;
      addr_reg   <= addr_next;
      data_reg   <= data_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      fun_reg    <= fun_next;
      rf_wr_en   <= wr_en_next;
      rf_rd_en   <= rd_en_next;
      alu_en     <= alu_en_next;
      rf_addr    <= rf_addr_next;
      rf_wr_data <= rf_wr_data_next;
      alu_fun    <= alu_fun_next;
      frame_err  <= err_next;
      err_code   <= code_next;
      idle       <= (state_next == IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder; timeout checks run when UART_CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       dn_busy = 1'b0;
  logic       rf_wr_en, rf_rd_en, alu_en, frame_err, idle;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic [3:0] alu_fun;
  logic [1:0] err_code;

  uart_cmd_decoder #(.ADDR_W(4), .TIMEOUT_CYC(16'd20)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .par_err(par_err), .stp_err(stp_err), .dn_busy(dn_busy),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_addr(rf_addr),
    .rf_wr_data(rf_wr_data), .alu_en(alu_en), .alu_fun(alu_fun),
    .frame_err(frame_err), .err_code(err_code), .idle(idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int a; int d; } ev_t;
  ev_t wr_q[$], rd_q[$], alu_q[$], err_q[$];
  ev_t ev;
  int  onehot_viol = 0;

  always @(negedge clk) begin
    ev.cyc = cyc;
    if (rf_wr_en)  begin ev.a = int'(rf_addr); ev.d = int'(rf_wr_data); wr_q.push_back(ev); end
    if (rf_rd_en)  begin ev.a = int'(rf_addr); ev.d = 0;                rd_q.push_back(ev); end
    if (alu_en)    begin ev.a = int'(alu_fun); ev.d = 0;                alu_q.push_back(ev); end
    if (frame_err) begin ev.a = int'(err_code); ev.d = 0;               err_q.push_back(ev); end
    if ((32'(rf_wr_en) + 32'(rf_rd_en) + 32'(alu_en)) > 1) onehot_viol++;
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_q();
    wr_q.delete(); rd_q.delete(); alu_q.delete(); err_q.delete();
  endtask

  // Called at a negedge: drive one byte for exactly one cycle; n is its cycle number.
  task automatic send(input logic [7:0] b, input logic pe, input logic se, output int n);
    rx_data = b; rx_valid = 1'b1; par_err = pe; stp_err = se;
    n = cyc;
    @(negedge clk);
    rx_valid = 1'b0; par_err = 1'b0; stp_err = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic exp_ev(input string tag, input int kind, input int i, input int c, input int a, input int d);
    ev_t e;
    int  sz;
    case (kind)
      0: sz = wr_q.size();
      1: sz = rd_q.size();
      2: sz = alu_q.size();
      default: sz = err_q.size();
    endcase
    check({tag, "_present"}, 32'(sz > i), 32'd1);
    if (sz > i) begin
      case (kind)
        0: e = wr_q[i];
        1: e = rd_q[i];
        2: e = alu_q[i];
        default: e = err_q[i];
      endcase
      check({tag, "_cyc"}, e.cyc, c);
      check({tag, "_val"}, e.a, a);
      if (kind == 0) check({tag, "_data"}, e.d, d);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    repeat (3) @(negedge clk);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_outs", {rf_wr_en, rf_rd_en, alu_en, frame_err, err_code, rf_addr, rf_wr_data, alu_fun}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // AA 05 3C: single write two cycles after the last byte
    send(8'hAA, 0, 0, n); send(8'h05, 0, 0, n); send(8'h3C, 0, 0, n);
    check("wr_idle_low", 32'(idle), 32'd0);
    wait_to(n + 3);
    check("wr_idle_back", 32'(idle), 32'd1);
    wait_to(n + 5);
    check("wr_count", wr_q.size(), 1);
    exp_ev("wr", 0, 0, n + 2, 5, 8'h3C);
    check("wr_hold_addr", 32'(rf_addr), 32'd5);
    check("wr_hold_data", 32'(rf_wr_data), 32'h3C);
    $display("[TB] frame AA 05 3C done at cycle %0d", cyc);
    clear_q();

    // CC 12 34 03 with no back-pressure
    send(8'hCC, 0, 0, n); send(8'h12, 0, 0, n); send(8'h34, 0, 0, n); send(8'h03, 0, 0, n);
    wait_to(n + 6);
    check("cc_idle_n6", 32'(idle), 32'd0);
    wait_to(n + 7);
    check("cc_idle_n7", 32'(idle), 32'd1);
    wait_to(n + 9);
    check("cc_wr_count", wr_q.size(), 2);
    check("cc_alu_count", alu_q.size(), 1);
    exp_ev("cc_wr0", 0, 0, n + 2, 0, 8'h12);
    exp_ev("cc_wr1", 0, 1, n + 4, 1, 8'h34);
    exp_ev("cc_alu", 2, 0, n + 6, 3, 0);
    $display("[TB] frame CC 12 34 03 done at cycle %0d", cyc);
    clear_q();

    // CC 56 78 0A with dn_busy high for 10 cycles before the second op
    send(8'hCC, 0, 0, n); send(8'h56, 0, 0, n); send(8'h78, 0, 0, n); send(8'h0A, 0, 0, n);
    wait_to(n + 2);
    dn_busy = 1'b1;
    wait_to(n + 12);
    dn_busy = 1'b0;
    wait_to(n + 15);
    check("ccb_idle_n15", 32'(idle), 32'd0);
    wait_to(n + 16);
    check("ccb_idle_n16", 32'(idle), 32'd1);
    wait_to(n + 20);
    check("ccb_wr_count", wr_q.size(), 2);
    check("ccb_alu_count", alu_q.size(), 1);
    exp_ev("ccb_wr0", 0, 0, n + 2, 0, 8'h56);
    exp_ev("ccb_wr1", 0, 1, n + 13, 1, 8'h78);
    exp_ev("ccb_alu", 2, 0, n + 15, 4'hA, 0);
    $display("[TB] frame CC 56 78 0A (stalled) done at cycle %0d", cyc);
    clear_q();

    // Bad opcode in IDLE
    send(8'h5A, 0, 0, n);
    check("bad_err_now", 32'(frame_err), 32'd1);
    check("bad_idle", 32'(idle), 32'd1);
    wait_to(n + 3);
    check("bad_err_count", err_q.size(), 1);
    exp_ev("bad_err", 3, 0, n + 1, 1, 0);
    $display("[TB] byte 5A rejected at cycle %0d", cyc);
    clear_q();

    // Parity error on operand aborts the read, then a clean read goes through
    send(8'hBB, 0, 0, n); send(8'h07, 1, 0, n);
    check("par_idle", 32'(idle), 32'd1);
    send(8'hBB, 0, 0, m); send(8'h07, 0, 0, m);
    wait_to(m + 4);
    check("par_rd_count", rd_q.size(), 1);
    check("par_err_count", err_q.size(), 1);
    exp_ev("par_err", 3, 0, n + 1, 2, 0);
    exp_ev("par_rd", 1, 0, m + 2, 7, 0);
    $display("[TB] frame BB 07 (parity) then BB 07 done at cycle %0d", cyc);
    clear_q();

    // Stop error on an opcode byte: dropped, next stray byte is a bad opcode
    send(8'hAA, 0, 1, n); send(8'h07, 0, 0, m);
    wait_to(m + 3);
    check("stp_err_count", err_q.size(), 2);
    exp_ev("stp_err0", 3, 0, n + 1, 2, 0);
    exp_ev("stp_err1", 3, 1, m + 1, 1, 0);
    check("stp_no_wr", wr_q.size(), 0);
    $display("[TB] stop-error opcode dropped at cycle %0d", cyc);
    clear_q();

    // Overrun during ISSUE while stalled; ALU still issues after dn_busy drops
    dn_busy = 1'b1;
    send(8'hDD, 0, 0, n); send(8'h14, 0, 0, n); send(8'h99, 0, 0, m);
    wait_to(n + 5);
    dn_busy = 1'b0;
    wait_to(n + 7);
    check("ovr_idle", 32'(idle), 32'd1);
    wait_to(n + 10);
    check("ovr_alu_count", alu_q.size(), 1);
    check("ovr_err_count", err_q.size(), 1);
    exp_ev("ovr_err", 3, 0, m + 1, 0, 0);
    exp_ev("ovr_alu", 2, 0, n + 6, 4, 0);
    $display("[TB] frame DD 14 with overrun done at cycle %0d", cyc);
    clear_q();

    // Asynchronous reset while a CC frame is issuing
    send(8'hCC, 0, 0, n); send(8'h11, 0, 0, n); send(8'h22, 0, 0, n); send(8'h05, 0, 0, n);
    wait_to(n + 2);
    check("mid_pulse", 32'(rf_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {rf_wr_en, rf_rd_en, alu_en, frame_err, err_code, rf_addr, rf_wr_data, alu_fun}, 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    repeat (10) @(negedge clk);
    check("post_rst_quiet", wr_q.size() + alu_q.size() + err_q.size(), 0);
    send(8'hAA, 0, 0, n); send(8'h03, 0, 0, n); send(8'hC3, 0, 0, n);
    wait_to(n + 4);
    exp_ev("post_rst_wr", 0, 0, n + 2, 3, 8'hC3);
    $display("[TB] reset mid-frame then AA 03 C3 done at cycle %0d", cyc);
    clear_q();

`ifdef UART_CMD_TIMEOUT_EN
    // Silence after AA 01 times out 20 cycles into WR_DATA
    send(8'hAA, 0, 0, n); send(8'h01, 0, 0, n);
    wait_to(n + 25);
    check("to_err_count", err_q.size(), 1);
    exp_ev("to_err", 3, 0, n + 21, 3, 0);
    check("to_idle", 32'(idle), 32'd1);
    check("to_no_wr", wr_q.size(), 0);
    clear_q();
    // A byte in the expiry cycle wins over the timeout
    send(8'hAA, 0, 0, n);
    wait_to(n + 20);
    send(8'h02, 0, 0, m);
    send(8'hFF, 0, 0, m);
    wait_to(m + 4);
    check("to_edge_no_err", err_q.size(), 0);
    exp_ev("to_edge_wr", 0, 0, m + 2, 2, 8'hFF);
    clear_q();
    send(8'hAA, 0, 0, n); send(8'h01, 0, 0, n); send(8'hFF, 0, 0, n);
    wait_to(n + 4);
    exp_ev("to_after_wr", 0, 0, n + 2, 1, 8'hFF);
    $display("[TB] timeout frames done at cycle %0d", cyc);
    clear_q();
`else
    // Without the timeout an operand state waits indefinitely
    send(8'hAA, 0, 0, n); send(8'h01, 0, 0, n);
    wait_to(n + 60);
    check("nto_no_err", err_q.size(), 0);
    check("nto_idle_low", 32'(idle), 32'd0);
    send(8'hFF, 0, 0, m);
    wait_to(m + 4);
    exp_ev("nto_wr", 0, 0, m + 2, 1, 8'hFF);
    $display("[TB] long-gap frame AA 01 .. FF done at cycle %0d", cyc);
    clear_q();
`endif

    check("onehot_pulses", onehot_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Byte-stream command decoder sitting directly downstream of the UART receiver.
- Consumes each received byte (`rx_data`/`rx_valid`) together with the receiver's parity and stop error flags.
- Assembles multi-byte command frames and issues register-file write/read and ALU requests to the system controller, one micro-op at a time, under a `dn_busy` back-pressure handshake.
- Malformed, corrupted, overrun or stalled frames are dropped and reported through a one-cycle error pulse carrying a code.

## Interface
Parameters:
- `ADDR_W`, 4: register-file address width; `rf_addr` is the low `ADDR_W` bits of the address byte.
- `TIMEOUT_CYC`, 16'd50000: maximum idle cycles between bytes inside a frame. Used only with the timeout feature compiled in.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle pulse, one per received byte.
- `par_err`  in  1  parity error for the current byte; sampled with `rx_valid`.
- `stp_err`  in  1  stop-bit error for the current byte; sampled with `rx_valid`.
- `dn_busy`  in  1  downstream cannot accept a micro-op.
- `rf_wr_en`  out  1  one-cycle register-file write pulse.
- `rf_rd_en`  out  1  one-cycle register-file read pulse.
- `rf_addr`  out  ADDR_W  register-file address; held stable from issue until the next issue.
- `rf_wr_data`  out  8  register-file write data; same holding rule as `rf_addr`.
- `alu_en`  out  1  one-cycle ALU start pulse.
- `alu_fun`  out  4  ALU function, from the low 4 bits of the function byte.
- `frame_err`  out  1  one-cycle error pulse.
- `err_code`  out  2  error code, valid with `frame_err`: 0 overrun, 1 bad opcode, 2 line error, 3 timeout.
- `idle`  out  1  high in state IDLE.

## Operation
Frames, first byte is the opcode:
- `0xAA` addr data: one register-file write of `data` to `addr`.
- `0xBB` addr: one register-file read of `addr`.
- `0xCC` A B fun: three micro-ops in order: write A to address 0, write B to address 1, then ALU with `fun`.
- `0xDD` fun: one ALU micro-op with `fun`.

FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN, ISSUE.
- IDLE with an opcode byte: go to the first operand state of that frame.
- IDLE with any other byte: `frame_err`, code 1; stay in IDLE.
- Operand states: each accepted byte is captured into its own register, then the FSM advances. After the final byte the FSM goes to ISSUE.
- Line error: `rx_valid` with `par_err|stp_err` in any state other than ISSUE drops the byte and raises `frame_err`, code 2.
  - In an operand state the frame is also aborted and the FSM returns to IDLE.
  - In IDLE the FSM stays in IDLE.
- ISSUE state, micro-op issue rule:
  - A micro-op issues at an edge where `dn_busy`=0 and no issue pulse is currently high. Minimum spacing between micro-ops is therefore 2 cycles.
  - After the last micro-op's edge, the FSM returns to IDLE.
- Overrun: `rx_valid` while in ISSUE drops the byte and raises `frame_err`, code 0. The frame in progress still completes.
- All outputs are registered.
- At most one of `rf_wr_en`, `rf_rd_en`, `alu_en` is high in any cycle.
- `frame_err` and an issue pulse may coincide.

## Timing
- Reset value of every output is 0, except `idle`, which is 1.
- Reset clears all captured bytes and the timeout counter and forces IDLE. Reset mid-frame or mid-ISSUE drops the frame with no pulses and no error.
- Latency: final byte on `rx_valid` in cycle N → ISSUE in cycle N+1 → first pulse high in cycle N+2, if `dn_busy`=0 in N+1.
- `0xCC` frame with `dn_busy` held low: pulses in N+2 (write address 0), N+4 (write address 1), N+6 (`alu_en`). `idle` is high from N+7.
- `dn_busy` high stalls issue indefinitely. The pending micro-op's pulse appears the cycle after the first cycle in which `dn_busy` is sampled low.
- Error pulse: `frame_err` is high in the cycle after the offending `rx_valid`.

## Configuration
Macro `UART_CMD_TIMEOUT_EN`:
- Defined:
  - A 16-bit counter clears on every `rx_valid` and counts in operand states.
  - When it reaches `TIMEOUT_CYC`-1, the frame aborts to IDLE with `frame_err`, code 3.
  - The counter saturates and never wraps.
  - Timeout and an `rx_valid` arriving in the same cycle: the byte wins and no timeout occurs.
  - The counter is idle in IDLE and ISSUE.
- Not defined: no counter is built and operand states wait indefinitely.

## Test plan
- Bytes `AA 05 3C`, `dn_busy`=0 → single `rf_wr_en` with `rf_addr`=5 and `rf_wr_data`=0x3C, two cycles after the last `rx_valid`. `idle` returns to 1.
- Bytes `CC 12 34 03`, `dn_busy`=0 → write (0, 0x12), write (1, 0x34), then `alu_en` with `alu_fun`=3, at 2-cycle spacing. Then hold `dn_busy`=1 for 10 cycles before the second op → that op is delayed accordingly, and there are no duplicate pulses.
- Byte `5A` in IDLE → `frame_err` with `err_code`=1; the FSM stays in IDLE.
- Bytes `BB` then `07` with `par_err`=1 → no `rf_rd_en`; `err_code`=2; next frame `BB 07` → `rf_rd_en` with `rf_addr`=7.
- `DD` followed by an extra byte during ISSUE while `dn_busy`=1 → overrun (`err_code`=0); `alu_en` still issues once `dn_busy` drops.
- With `UART_CMD_TIMEOUT_EN` and `TIMEOUT_CYC`=20: `AA 01`, then silence → `frame_err` with `err_code`=3 about 20 cycles later; next `AA 01 FF` → normal write. Also assert `rst_n` low mid-`CC` frame → all outputs 0 and `idle`=1 immediately.
